// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: bundles the core load/store request/response signals
// and the single-port data RAM port of mem_access_ctrl.
//   req_valid/req_ready/req_we/req_mode/req_addr/req_wdata : core request
//   rsp_valid/rsp_rdata/rsp_err                            : core response
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata             : RAM port
// Modports: slave = the controller, master = core plus RAM side.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_mode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-3:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle sequencer between the core load/store port and
// a single-port synchronous data RAM. Loads are a read plus sign/zero
// extension, sub-word stores a read-modify-write, word stores a direct write.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_access_ctrl_if.slave (request, response and RAM port)
// Build option: define MISALIGN_TRAP_EN to answer misaligned accesses
// (half at offset 3, word at non-zero offset) with rsp_err and no RAM access.
// Without it rsp_err is 0, word accesses ignore addr[1:0], a half store at
// offset 3 writes the word back unchanged and a half load at offset 3 yields 0.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

    state_t                state, state_nx;
    logic                  cap_we;
    logic [2:0]            cap_mode;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            off;
    logic [4:0]            lane_shift;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;
    logic                  ram_en, ram_we, req_ready, rsp_valid;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign off        = cap_addr[1:0];
    assign lane_shift = {off, 3'b000};

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] o);
        return ((mode[1:0] == 2'b01) && (o == 2'b11)) || (mode[1] && (o != 2'b00));
    endfunction

    logic req_mis, cap_mis;
    assign req_mis = is_misaligned(bus.req_mode, bus.req_addr[1:0]);
    assign cap_mis = is_misaligned(cap_mode, off);
`endif

    // Lane extraction for loads and lane merge for sub-word stores, both
    // taken from the word returned by the RAM in the DATA cycle.
    always_comb begin
        byte_lane = bus.ram_rdata[lane_shift +: 8];
        half_lane = '0;
        case (off)
            2'd0:    half_lane = bus.ram_rdata[15:0];
            2'd1:    half_lane = bus.ram_rdata[23:8];
            2'd2:    half_lane = bus.ram_rdata[31:16];
            default: half_lane = '0;
        endcase
        load_val = bus.ram_rdata;
        merged   = bus.ram_rdata;
        case (cap_mode[1:0])
            2'b00: begin
                load_val = {{(DATA_WIDTH-8){byte_lane[7] & ~cap_mode[2]}}, byte_lane};
                merged   = (bus.ram_rdata & ~(BYTE_MASK << lane_shift))
                         | (DATA_WIDTH'(cap_wdata[7:0]) << lane_shift);
            end
            2'b01: begin
                // A half at offset 3 straddles the word: load gives 0 and
                // the store writes the word back untouched.
                if (off == 2'b11) begin
                    load_val = '0;
                end else begin
                    load_val = {{(DATA_WIDTH-16){half_lane[15] & ~cap_mode[2]}}, half_lane};
                    merged   = (bus.ram_rdata & ~(HALF_MASK << lane_shift))
                             | (DATA_WIDTH'(cap_wdata[15:0]) << lane_shift);
                end
            end
            default: begin
                load_val = bus.ram_rdata;
                merged   = bus.ram_rdata;
            end
        endcase
    end

    always_comb begin
        state_nx  = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
`ifdef MISALIGN_TRAP_EN
                    if (req_mis) state_nx = RESP; else
`endif
                    if (bus.req_we && bus.req_mode[1]) state_nx = WR;
                    else                               state_nx = RD;
                end
            end
            RD: begin
                ram_en   = 1'b1;
                state_nx = DATA;
            end
            DATA: begin
                if (cap_we) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = merged;
                end
                state_nx = RESP;
            end
            WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = cap_wdata;
                state_nx  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_mode  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (bus.req_valid && (state == IDLE)) begin
                cap_we    <= bus.req_we;
                cap_mode  <= bus.req_mode;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if ((state == DATA) && !cap_we) rdata_q <= load_val;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.ram_en    = ram_en;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = cap_addr[ADDR_WIDTH-1:2];
    assign bus.ram_wdata = ram_wdata;
`ifdef MISALIGN_TRAP_EN
    assign bus.rsp_err   = (state == RESP) && cap_mis;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifc ();
    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Synchronous single-port RAM (64 words) with a backdoor write port.
    logic [31:0] ram [0:63];
    logic        bk_we;
    logic [5:0]  bk_addr;
    logic [31:0] bk_data;
    always @(posedge clk) begin
        if (bk_we) ram[bk_addr] <= bk_data;
        else if (ifc.ram_en) begin
            if (ifc.ram_we) ram[ifc.ram_addr[5:0]] <= ifc.ram_wdata;
            else            ifc.ram_rdata <= ram[ifc.ram_addr[5:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_rdata;
    int          exp_lat, exp_writes;
    logic        exp_err;

    // Observations of one transaction
    int          obs_wait, obs_lat, obs_writes, obs_reads, obs_ready;
    logic [13:0] obs_waddr;
    logic [31:0] obs_wdata, obs_rdata;
    logic        obs_err, obs_pulse_ok;

    // Behavioural model: byte-wise arithmetic on the reference memory.
    task automatic model_access(input logic we, input logic [2:0] mode,
                                input logic [15:0] addr, input logic [31:0] wdata);
        int unsigned nb, off, w;
        logic [31:0] word, val;
        logic        mis;
        nb  = mode[1] ? 4 : (mode[0] ? 2 : 1);
        off = addr % 4;
        w   = (addr / 4) % 64;
        mis = (nb == 2 && off == 3) || (nb == 4 && off != 0);
        if (nb == 4) off = 0;
        exp_err    = TRAP && mis;
        exp_writes = 0;
        exp_lat    = (we && nb == 4) ? 2 : 3;
        if (exp_err) exp_lat = 1;
        else begin
            word = ref_mem[w];
            if (we) begin
                exp_writes = 1;
                if (off + nb <= 4)
                    for (int unsigned i = 0; i < nb; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
                ref_mem[w] = word;
            end else begin
                val = '0;
                if (off + nb <= 4) begin
                    for (int unsigned i = 0; i < nb; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
                    if (nb < 4 && !mode[2] && val[8*nb-1])
                        for (int unsigned j = nb; j < 4; j++) val[8*j +: 8] = 8'hFF;
                end
                ref_rdata = val;
            end
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Drives one request (caller is positioned at a negedge) and records what
    // the DUT does until one cycle after its response. Ends at a negedge.
    task automatic run_txn(input logic we, input logic [2:0] mode, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic hold);
        logic done;
        ifc.req_we = we; ifc.req_mode = mode; ifc.req_addr = addr; ifc.req_wdata = wdata;
        ifc.req_valid = 1'b1;
        obs_wait = 0; obs_lat = 0; obs_writes = 0; obs_reads = 0; obs_ready = 0;
        obs_waddr = '0; obs_wdata = '0; obs_err = 1'b0; obs_rdata = '0; obs_pulse_ok = 1'b0;
        while (!ifc.req_ready && obs_wait < 20) begin
            @(negedge clk);
            obs_wait++;
        end
        @(posedge clk); #1;
        if (!hold) ifc.req_valid = 1'b0;
        done = 1'b0;
        while (!done && obs_lat < 20) begin
            @(negedge clk);
            obs_lat++;
            if (ifc.ram_en && ifc.ram_we) begin
                obs_writes++; obs_waddr = ifc.ram_addr; obs_wdata = ifc.ram_wdata;
            end
            if (ifc.ram_en && !ifc.ram_we) obs_reads++;
            if (ifc.req_ready) obs_ready++;
            if (ifc.rsp_valid) begin
                done = 1'b1; obs_err = ifc.rsp_err; obs_rdata = ifc.rsp_rdata;
            end
        end
        if (!done) obs_lat = -1;
        @(negedge clk);
        obs_pulse_ok = !ifc.rsp_valid && ifc.req_ready && !ifc.ram_en;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", ifc.req_ready); end
        checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", ifc.rsp_valid); end
        checks++; if (ifc.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", ifc.rsp_err); end
        checks++; if (ifc.ram_en !== 1'b0 || ifc.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_ctl: got en=%b we=%b expected 0 0", ifc.ram_en, ifc.ram_we); end
        checks++; if (ifc.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", ifc.rsp_rdata); end
        @(negedge clk); rst_n = 1'b1; ref_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_byte_store;
        poke(6'h10, 32'hAABBCCDD); @(negedge clk);
        model_access(1'b1, 3'b000, 16'h0041, 32'h0000_0012);
        run_txn(1'b1, 3'b000, 16'h0041, 32'h0000_0012, 1'b0);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", obs_lat); end
        checks++; if (obs_writes !== 1 || obs_waddr !== 14'h10) begin errors++; $display("FAIL sb_write: got n=%0d addr=%h expected 1 0010", obs_writes, obs_waddr); end
        checks++; if (obs_wdata !== 32'hAABB12DD) begin errors++; $display("FAIL sb_wdata: got %h expected aabb12dd", obs_wdata); end
        checks++; if (ram[16] !== ref_mem[16]) begin errors++; $display("FAIL sb_ram: got %h expected %h", ram[16], ref_mem[16]); end
        checks++; if (obs_pulse_ok !== 1'b1) begin errors++; $display("FAIL sb_pulse: got %b expected 1", obs_pulse_ok); end
    endtask

    task automatic test_half;
        poke(6'h10, 32'h11223344); @(negedge clk);
        model_access(1'b1, 3'b001, 16'h0042, 32'h1234BEEF);
        run_txn(1'b1, 3'b001, 16'h0042, 32'h1234BEEF, 1'b0);
        checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL sh_latency: got %0d expected %0d", obs_lat, exp_lat); end
        checks++; if (obs_wdata !== 32'hBEEF3344) begin errors++; $display("FAIL sh_wdata: got %h expected beef3344", obs_wdata); end
        model_access(1'b0, 3'b101, 16'h0042, 32'h0);
        run_txn(1'b0, 3'b101, 16'h0042, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_rdata: got %h expected 0000beef", obs_rdata); end
        checks++; if (obs_writes !== 0 || obs_lat !== exp_lat) begin errors++; $display("FAIL lhu_timing: got writes=%0d lat=%0d expected 0 %0d", obs_writes, obs_lat, exp_lat); end
    endtask

    task automatic test_sign_ext;
        poke(6'h10, 32'h80FF0000); @(negedge clk);
        model_access(1'b0, 3'b000, 16'h0043, 32'h0);
        run_txn(1'b0, 3'b000, 16'h0043, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
        model_access(1'b0, 3'b100, 16'h0043, 32'h0);
        run_txn(1'b0, 3'b100, 16'h0043, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", obs_rdata); end
        model_access(1'b1, 3'b000, 16'h0040, 32'h77);
        run_txn(1'b1, 3'b000, 16'h0040, 32'h77, 1'b0);
        checks++; if (ifc.rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL store_keeps_rdata: got %h expected 00000080", ifc.rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        model_access(1'b1, 3'b010, 16'h0020, 32'hDEADBEEF);
        run_txn(1'b1, 3'b010, 16'h0020, 32'hDEADBEEF, 1'b1);
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", obs_lat); end
        checks++; if (obs_reads !== 0 || obs_writes !== 1) begin errors++; $display("FAIL sw_access: got reads=%0d writes=%0d expected 0 1", obs_reads, obs_writes); end
        checks++; if (obs_waddr !== 14'h8 || obs_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write: got %h:%h expected 0008:deadbeef", obs_waddr, obs_wdata); end
        checks++; if (obs_ready !== 0) begin errors++; $display("FAIL sw_ready_busy: got %0d ready cycles expected 0", obs_ready); end
        model_access(1'b1, 3'b011, 16'h0024, 32'h01020304);
        run_txn(1'b1, 3'b011, 16'h0024, 32'h01020304, 1'b0);
        checks++; if (obs_wait !== 0 || obs_lat !== 2) begin errors++; $display("FAIL b2b_second: got wait=%0d lat=%0d expected 0 2", obs_wait, obs_lat); end
        checks++; if (obs_waddr !== 14'h9) begin errors++; $display("FAIL b2b_addr: got %h expected 0009", obs_waddr); end
    endtask

    task automatic test_reset_mid_op;
        poke(6'h10, 32'hAABBCCDD); @(negedge clk);
        ifc.req_we = 1'b1; ifc.req_mode = 3'b000; ifc.req_addr = 16'h0041; ifc.req_wdata = 32'h55;
        ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        checks++; if (ifc.ram_en !== 1'b1 || ifc.ram_we !== 1'b0) begin errors++; $display("FAIL rd_cycle: got en=%b we=%b expected 1 0", ifc.ram_en, ifc.ram_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ifc.ram_en !== 1'b0 || ifc.ram_we !== 1'b0) begin errors++; $display("FAIL midrst_ram: got en=%b we=%b expected 0 0", ifc.ram_en, ifc.ram_we); end
        checks++; if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_hs: got valid=%b ready=%b expected 0 1", ifc.rsp_valid, ifc.req_ready); end
        checks++; if (ifc.rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 00000000", ifc.rsp_rdata); end
        ref_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ram[16] !== 32'hAABBCCDD) begin errors++; $display("FAIL midrst_ram_word: got %h expected aabbccdd", ram[16]); end
        model_access(1'b1, 3'b000, 16'h0041, 32'h12);
        run_txn(1'b1, 3'b000, 16'h0041, 32'h12, 1'b0);
        checks++; if (obs_lat !== 3 || obs_wdata !== 32'hAABB12DD) begin errors++; $display("FAIL after_rst_sb: got lat=%0d wdata=%h expected 3 aabb12dd", obs_lat, obs_wdata); end
    endtask

    task automatic test_misaligned;
        logic [31:0] prev;
        poke(6'h08, 32'h0); @(negedge clk);
        prev = ifc.rsp_rdata;
        model_access(1'b1, 3'b010, 16'h0022, 32'hCAFEF00D);
        run_txn(1'b1, 3'b010, 16'h0022, 32'hCAFEF00D, 1'b0);
        checks++; if (obs_lat !== (TRAP ? 1 : 2)) begin errors++; $display("FAIL mis_sw_latency: got %0d expected %0d", obs_lat, TRAP ? 1 : 2); end
        checks++; if (obs_err !== TRAP) begin errors++; $display("FAIL mis_sw_err: got %b expected %b", obs_err, TRAP); end
        checks++; if (obs_writes !== (TRAP ? 0 : 1)) begin errors++; $display("FAIL mis_sw_writes: got %0d expected %0d", obs_writes, TRAP ? 0 : 1); end
        checks++; if (ram[8] !== (TRAP ? 32'h0 : 32'hCAFEF00D)) begin errors++; $display("FAIL mis_sw_ram: got %h expected %h", ram[8], TRAP ? 32'h0 : 32'hCAFEF00D); end
        checks++; if (obs_rdata !== prev) begin errors++; $display("FAIL mis_sw_rdata: got %h expected %h", obs_rdata, prev); end
        model_access(1'b0, 3'b001, 16'h0023, 32'h0);
        run_txn(1'b0, 3'b001, 16'h0023, 32'h0, 1'b0);
        checks++; if (obs_lat !== exp_lat || obs_err !== exp_err) begin errors++; $display("FAIL mis_lh: got lat=%0d err=%b expected %0d %b", obs_lat, obs_err, exp_lat, exp_err); end
        checks++; if (obs_rdata !== ref_rdata) begin errors++; $display("FAIL mis_lh_rdata: got %h expected %h", obs_rdata, ref_rdata); end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  mode;
        logic [15:0] addr;
        logic [31:0] wdata;
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom); mode = 3'($urandom); addr = 16'($urandom_range(0, 255)); wdata = $urandom;
            model_access(we, mode, addr, wdata);
            run_txn(we, mode, addr, wdata, 1'b0);
            checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, obs_lat, exp_lat); end
            checks++; if (obs_writes !== exp_writes) begin errors++; $display("FAIL rnd%0d_writes: got %0d expected %0d", n, obs_writes, exp_writes); end
            checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", n, obs_err, exp_err); end
            checks++; if (obs_rdata !== ref_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, obs_rdata, ref_rdata); end
            checks++; if (obs_pulse_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_pulse: got %b expected 1", n, obs_pulse_ok); end
        end
    endtask

    task automatic test_final_mem;
        for (int i = 0; i < 64; i++) begin
            checks++; if (ram[i] !== ref_mem[i]) begin errors++; $display("FAIL mem[%0d]: got %h expected %h", i, ram[i], ref_mem[i]); end
        end
    endtask

    initial begin
        ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_mode = '0;
        ifc.req_addr = '0; ifc.req_wdata = '0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0; ref_rdata = '0;
        test_reset;
        test_byte_store;
        test_half;
        test_sign_ext;
        test_back_to_back;
        test_reset_mid_op;
        test_misaligned;
        test_random;
        test_final_mem;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle sequencer between the core load/store port and a single-port synchronous data RAM.
- Sub-word stores become a read-modify-write: read the word, merge bytes/halves, write it back.
- Loads become read plus sign/zero extension.
- Full-word stores write directly.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 16, byte-address width of req_addr; RAM word address is ADDR_WIDTH-2 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; the request is accepted on a clock edge with req_valid&&req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 treated as word); [2] unsigned-load flag.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  extended load result, registered.
- rsp_err  out  1  misaligned-access flag, valid with rsp_valid.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH-2  RAM word address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en=1 && ram_we=0.

Behaviour:
- Reset values: state IDLE, all request fields captured to 0, rsp_rdata=0, rsp_valid=0, rsp_err=0, ram_en=0, ram_we=0.
- RAM port outputs are decoded from state and the captured request fields only; no combinational path from req_* to ram_*.
- On accept: capture we, mode, addr, wdata; off = addr[1:0].
- States:
  - IDLE: req_ready=1.
    - On accept: word store -> WR; load or sub-word store -> RD.
  - RD: ram_en=1, ram_we=0, ram_addr=addr[ADDR_WIDTH-1:2]. -> DATA.
  - DATA: ram_rdata is valid this cycle.
    - Load: rsp_rdata <= extended lane. Byte lane = bits [8*off+7 : 8*off]; half lane = bits [8*off+15 : 8*off]. Sign-extend if mode[2]=0, zero-extend if mode[2]=1; word loads unextended.
    - Store: ram_en=1, ram_we=1, ram_wdata = ram_rdata with the selected byte/half lane replaced by wdata[7:0] or wdata[15:0]; all other bits unchanged.
    - -> RESP.
  - WR: ram_en=1, ram_we=1, ram_wdata=wdata. -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
- Latency, accept edge to rsp_valid cycle: load / sub-word store 3 cycles (RD, DATA, RESP); word store 2 cycles (WR, RESP).
- Maximum throughput: one access per 4 cycles (loads, sub-word stores) or 3 cycles (word stores).
- No response backpressure; rsp_valid is a pulse.
- rsp_rdata holds its value until the next load completes; stores never modify it.
- req_valid in any non-IDLE state is ignored; the requester must hold it until accepted.
- Misaligned access: half at off=3, or word at off!=0; behaviour per the optional feature.
- Reset asserted mid-operation:
  - Immediately (asynchronously) returns to IDLE and forces ram_en/ram_we/rsp_valid to 0.
  - A write is issued only in the DATA/WR cycle; a reset before that edge leaves the RAM untouched.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned request goes IDLE -> RESP directly.
  - No RAM access; rsp_err=1; rsp_rdata unchanged.
- Undefined:
  - rsp_err is tied 0.
  - Word access ignores addr[1:0] and is handled as aligned.
  - Half store at off=3 follows the RD/DATA path but writes back ram_rdata unchanged.
  - Half load at off=3 sets rsp_rdata=0.

Test Plan:
- Reset, then byte store: mem[0x10]=0xAABBCCDD; SB addr 0x41, wdata 0x12 -> RAM written 0xAABB12DD in DATA cycle; rsp_valid 3 cycles after accept.
- Half store / unsigned half load: SH addr 0x42 wdata 0xBEEF onto 0x11223344 -> 0xBEEF3344; then LHU addr 0x42 -> rsp_rdata 0x0000BEEF.
- Sign extension: LB addr 0x43 on word 0x80FF0000 -> 0xFFFFFF80; LBU same address -> 0x00000080.
- Word store and req_ready: SW addr 0x20 wdata 0xDEADBEEF -> no read cycle, write in WR, rsp_valid 2 cycles after accept; req_valid held high throughout -> second request accepted only in IDLE.
- Reset mid-operation: assert rst_n=0 during RD of SB -> ram_en=0 immediately, word unchanged, outputs at reset values, next request processed normally.
- Misaligned SW addr 0x22: with MISALIGN_TRAP_EN -> rsp_err=1 one cycle after accept, ram_we never 1; without -> word written at 0x20, rsp_err=0.
